sw_debouncer: RTL
=================

# sw_debouncer

Per-bit synchroniser and debouncer for the board slide switches. It sits directly upstream of the adder lab tops and replaces raw `SW` with clean, glitch-free levels, so the adder instances and `LEDR` see only settled operands. It also produces optional one-cycle rise/fall pulses, so downstream sequential stages can react once per switch flip.

## Interface
- `WIDTH`, default 10: number of switch bits handled.
- `DEBOUNCE_CYCLES`, default 500_000: consecutive stable cycles required before an output changes (10 ms at 50 MHz). Legal range ≥ 1.
- `clk`  input  1: single system clock, all logic on rising edge.
- `rst_n`  input  1: reset, synchronous, active-low.
- `sw_raw`  input  WIDTH: asynchronous switch levels straight from the pins.
- `sw_clean`  output  WIDTH: debounced, synchronised switch levels.
- `sw_rise`  output  WIDTH: one-cycle pulse per bit on a clean 0→1 change.
- `sw_fall`  output  WIDTH: one-cycle pulse per bit on a clean 1→0 change.

## Operation
- Each bit is independent. There is no cross-bit interaction.
- Synchroniser: `sw_raw[i]` passes through a 2-flop chain (`s1`, `s2`).
- Counter: per-bit, width `$clog2(DEBOUNCE_CYCLES+1)`. At each edge:
  - If `s2 == sw_clean[i]`: counter ← 0.
  - Else if counter == `DEBOUNCE_CYCLES-1`: `sw_clean[i]` ← `s2` and counter ← 0.
  - Else: counter ← counter + 1.
- A disagreement lasting fewer than `DEBOUNCE_CYCLES` consecutive cycles at `s2` never reaches `sw_clean`. Any agreement cycle restarts the count from 0.
- Pulses:
  - `sw_rise[i]` is registered and is high for exactly the one cycle in which `sw_clean[i]` first shows 1 after being 0.
  - `sw_fall[i]` follows the same rule for 1→0.
  - Both are never high together for the same bit.
  - Several bits may pulse in the same cycle.
- `DEBOUNCE_CYCLES == 1`: `sw_clean` follows `s2` with one cycle delay. Pulses still apply.
- Counter saturation is impossible: the counter clears on reaching `DEBOUNCE_CYCLES-1`.

## Timing
- Reset (`rst_n` low at an edge) sets `s1`, `s2`, `sw_clean`, counters, `sw_rise` and `sw_fall` to 0.
- Latency: `sw_raw` first sampled at edge k, then held stable. `sw_clean` (and the pulse) updates at edge k+1+`DEBOUNCE_CYCLES`.
- Reset mid-count discards any partial count. Outputs return to 0 at that edge.
- Switches held high through reset release give a `sw_rise` pulse `DEBOUNCE_CYCLES`+2 edges after the first edge with `rst_n` high.
- Input toggling every cycle: `sw_clean` holds its value indefinitely.

## Configuration
- Macro: `SW_DEBOUNCER_EDGE_PULSE_EN`.
- Defined: pulse registers and logic are built as described above.
- Undefined: `sw_rise` and `sw_fall` ports remain but are tied to constant 0, and no pulse flops are built. `sw_clean` behaviour is identical in both cases.

## Structure
- Package `sw_debouncer_pkg` holds:
  - `SW_SYNC_STAGES` = 2
  - `SW_DEBOUNCE_DEFAULT` = 500_000
  - `SW_WIDTH_DEFAULT` = 10
- One sub-module, `sw_debounce_bit`, holds the synchroniser, counter, clean flop and pulse flops for one bit. The top instantiates it `WIDTH` times in a generate loop.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and `WIDTH` = 10.
- Reset: `sw_raw`=10'h3FF with `rst_n` low for 3 edges → `sw_clean`=0, `sw_rise`=0 and `sw_fall`=0 throughout. After release, `sw_rise`=10'h3FF for exactly one cycle and `sw_clean`=10'h3FF, both at the 6th edge after release.
- Clean press: `sw_raw[0]` 0→1 sampled at edge k and held → `sw_clean[0]`=1 at edge k+5. `sw_rise[0]` is high for that one cycle only, and `sw_fall` stays 0.
- Glitch: `sw_raw[1]` high for 3 cycles, then low → `sw_clean[1]` and `sw_rise[1]` stay 0.
- Bounce: `sw_raw[2]` pattern 1,0,1,1,0,1,1,1,1,1 → a single `sw_rise[2]` pulse, 5 edges after the last 0→1 sample.
- Release plus simultaneous bits: `sw_raw[3]` and `sw_raw[4]` fall together after settling high → one `sw_fall` pulse covering bits 3 and 4 in the same cycle, and `sw_clean[4:3]`=0.
- Reset mid-count: `rst_n` low 2 cycles after a press on bit 5 → counter restarts and `sw_clean[5]` rises 6 edges after release. With the macro undefined, the same scenarios show `sw_rise` and `sw_fall` stuck at 0 and identical `sw_clean`.

Source files
------------

// File: rtl/sw_debouncer_pkg.sv
// Shared constants for the slide-switch debouncer.
// The sub-module sizes its stable-cycle counter with sw_cnt_width().
package sw_debouncer_pkg;

  localparam int SW_SYNC_STAGES      = 2;
  localparam int SW_DEBOUNCE_DEFAULT = 500_000;
  localparam int SW_WIDTH_DEFAULT    = 10;

  // Counter must be able to hold DEBOUNCE_CYCLES-1. Never narrower than 1 bit.
  function automatic int sw_cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser, stable-cycle counter, clean flop and,
// when SW_DEBOUNCER_EDGE_PULSE_EN is defined, registered rise/fall pulses.
module sw_debounce_bit
  import sw_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int            CW       = sw_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SW_SYNC_STAGES-1:0] sync;
  logic                      synced;
  logic [CW-1:0]             cnt;
  logic [CW-1:0]             cnt_next;
  logic                      clean_next;
  logic                      settle;

  assign synced = sync[SW_SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SW_SYNC_STAGES-2:0], raw};
    end
  end

  // settle marks the single edge on which a long enough disagreement lands.
  always_comb begin
    settle     = (synced != clean) && (cnt == CNT_LAST);
    clean_next = clean;
    cnt_next   = cnt;
    if (synced == clean) begin
      cnt_next = '0;
    end else if (settle) begin
      clean_next = synced;
      cnt_next   = '0;
    end else begin
      cnt_next = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clean <= 1'b0;
      cnt   <= '0;
    end else begin
      clean <= clean_next;
      cnt   <= cnt_next;
    end
  end

`ifdef SW_DEBOUNCER_EDGE_PULSE_EN
  // Pulses load on the same edge as clean, so they line up with the new level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= settle & synced;
      fall <= settle & ~synced;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/sw_debouncer.sv
// Per-bit synchroniser/debouncer for the board slide switches.
// Optional rise/fall pulses are built only with SW_DEBOUNCER_EDGE_PULSE_EN.
module sw_debouncer
  import sw_debouncer_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH_DEFAULT,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (sw_raw[i]),
      .clean(sw_clean[i]),
      .rise (sw_rise[i]),
      .fall (sw_fall[i])
    );
  end

endmodule
